// File: rtl/gray_step_checker_pkg.sv
// Shared definitions for the Gray step checker: FSM state encoding, step classes
// and the default code width (must match the upstream gray_counter).
package gray_step_checker_pkg;

    localparam int DEF_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CL_HOLD = 2'd0,
        CL_UP   = 2'd1,
        CL_DOWN = 2'd2,
        CL_ERR  = 2'd3
    } step_t;

endpackage

// File: rtl/gray_step_checker_gray2bin.sv
// Purely combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray2bin
    import gray_step_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^(i_gray >> i);
    end

endmodule

// File: rtl/gray_step_checker.sv
// Classifies each accepted Gray sample against the previous one (hold, +1, -1, illegal),
// counts illegal jumps and tracks a net signed position.
module gray_step_checker
    import gray_step_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ECW   = 4,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    output logic             step_up,
    output logic             step_down,
    output logic             hold,
    output logic             err,
    output logic             err_sticky,
    output logic [ECW-1:0]   err_cnt,
    output logic [PW-1:0]    pos_cnt,
    output state_t           dbg_state
);

    // bin_out doubles as the previous-sample register.
    logic [WIDTH-1:0] r_bin;
    logic             r_out_valid, r_up, r_down, r_hold, r_err, r_sticky;
    logic [ECW-1:0]   r_err_cnt;
    logic [PW-1:0]    r_pos;
    state_t           r_state;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_diff;
    step_t            w_step;
    logic             w_new_err;
    logic             w_clear;
    logic [ECW-1:0]   w_cnt_base;
    logic [ECW-1:0]   w_cnt_next;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .i_gray (gray_in),
        .o_bin  (w_bin)
    );

    assign w_diff = w_bin - r_bin;

    always_comb begin
        w_step = CL_ERR;
        if (w_diff == '0)
            w_step = CL_HOLD;
        else if (w_diff == WIDTH'(1))
            w_step = CL_UP;
        else if (w_diff == '1)
            w_step = CL_DOWN;
    end

    // An illegal jump beats a simultaneous clear: the count restarts at one.
    assign w_new_err  = in_valid && (r_state != ST_EMPTY) && (w_step == CL_ERR);
    assign w_clear    = err_clr && !w_new_err;
    assign w_cnt_base = err_clr ? '0 : r_err_cnt;
    assign w_cnt_next = (&w_cnt_base) ? w_cnt_base : w_cnt_base + ECW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin       <= '0;
            r_out_valid <= 1'b0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_hold      <= 1'b0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
            r_err_cnt   <= '0;
            r_pos       <= '0;
            r_state     <= ST_EMPTY;
        end else begin
            r_out_valid <= 1'b0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_hold      <= 1'b0;
            r_err       <= 1'b0;
            if (in_valid) begin
                r_out_valid <= 1'b1;
                r_bin       <= w_bin;
                if (r_state == ST_EMPTY) begin
                    r_state <= ST_TRACK;
                end else begin
                    case (w_step)
                        CL_HOLD: r_hold <= 1'b1;
                        CL_UP: begin
                            r_up  <= 1'b1;
                            r_pos <= r_pos + PW'(1);
                        end
                        CL_DOWN: begin
                            r_down <= 1'b1;
                            r_pos  <= r_pos - PW'(1);
                        end
                        CL_ERR: begin
                            r_err     <= 1'b1;
                            r_sticky  <= 1'b1;
                            r_err_cnt <= w_cnt_next;
                            r_state   <= ST_FAULT;
                        end
                    endcase
                end
            end
            if (w_clear) begin
                r_err_cnt <= '0;
                r_sticky  <= 1'b0;
                if (r_state == ST_FAULT)
                    r_state <= ST_TRACK;
            end
        end
    end

    assign bin_out    = r_bin;
    assign out_valid  = r_out_valid;
    assign step_up    = r_up;
    assign step_down  = r_down;
    assign hold       = r_hold;
    assign err        = r_err;
    assign err_sticky = r_sticky;
    assign err_cnt    = r_err_cnt;
    assign pos_cnt    = r_pos;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_gray_step_checker.sv
// Directed bench for gray_step_checker: expected responses are queued at issue time and
// a monitor pops and compares them whenever out_valid is seen.
module tb_gray_step_checker;
    import gray_step_checker_pkg::*;

    localparam int WIDTH = 3;
    localparam int ECW   = 2;
    localparam int PW    = 8;
    localparam int EW    = WIDTH + 5 + ECW + PW;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] gray_in;
    logic             in_valid;
    logic             err_clr;
    logic [WIDTH-1:0] bin_out;
    logic             out_valid, step_up, step_down, hold, err, err_sticky;
    logic [ECW-1:0]   err_cnt;
    logic [PW-1:0]    pos_cnt;
    state_t           dbg_state;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] act;
    logic [EW-1:0] mon_exp;
    int            checks;
    int            errors;

    gray_step_checker #(.WIDTH(WIDTH), .ECW(ECW), .PW(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_in    (gray_in),
        .in_valid   (in_valid),
        .err_clr    (err_clr),
        .bin_out    (bin_out),
        .out_valid  (out_valid),
        .step_up    (step_up),
        .step_down  (step_down),
        .hold       (hold),
        .err        (err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .pos_cnt    (pos_cnt),
        .dbg_state  (dbg_state)
    );

    assign act = {bin_out, step_up, step_down, hold, err, err_sticky, err_cnt, pos_cnt};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    function automatic logic [EW-1:0] pk(input logic [WIDTH-1:0] b, input logic u, input logic d,
                                         input logic h, input logic e, input logic s,
                                         input logic [ECW-1:0] c, input logic [PW-1:0] p);
        return {b, u, d, h, e, s, c, p};
    endfunction

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_valid got=%h expected no output", act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (act !== mon_exp) begin
                        errors++;
                        $display("FAIL sample got=%h exp=%h", act, mon_exp);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [WIDTH-1:0] g, input logic clr, input logic [EW-1:0] e);
        @(negedge clk);
        gray_in  = g;
        in_valid = 1'b1;
        err_clr  = clr;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic clr, input logic [EW-1:0] e, input state_t st);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            err_clr  = clr && (i == 0);
            gray_in  = WIDTH'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || act !== e || dbg_state !== st) begin
                errors++;
                $display("FAIL idle got=%b/%h/%0d exp=0/%h/%0d", out_valid, act, dbg_state, e, st);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        gray_in  = 3'b111;
        err_clr  = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || act !== '0 || dbg_state !== ST_EMPTY) begin
            errors++;
            $display("FAIL reset got=%b/%h/%0d exp=0/0/0", out_valid, act, dbg_state);
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    logic [WIDTH-1:0] t1_g [9];
    logic [WIDTH-1:0] alt_g [2];
    logic [WIDTH-1:0] alt_b [2];

    initial begin
        t1_g  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        alt_g = '{3'b101, 3'b011};
        alt_b = '{3'd6, 3'd2};
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        gray_in  = '0;
        repeat (2) @(posedge clk);

        // full upward lap including the 7 -> 0 wrap
        do_reset();
        send(t1_g[0], 1'b0, pk(3'd0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
        for (int k = 1; k < 9; k++)
            send(t1_g[k], 1'b0, pk(WIDTH'(k % 8), 1, 0, 0, 0, 0, 2'd0, PW'(k)));
        idle(1, 1'b0, pk(3'd0, 0, 0, 0, 0, 0, 2'd0, 8'd8), ST_TRACK);

        // downward wrap 0 -> 7 -> 6
        do_reset();
        send(3'b000, 1'b0, pk(3'd0, 0, 0, 0, 0, 0, 2'd0, 8'h00));
        send(3'b100, 1'b0, pk(3'd7, 0, 1, 0, 0, 0, 2'd0, 8'hFF));
        send(3'b101, 1'b0, pk(3'd6, 0, 1, 0, 0, 0, 2'd0, 8'hFE));
        idle(1, 1'b0, pk(3'd6, 0, 0, 0, 0, 0, 2'd0, 8'hFE), ST_TRACK);

        // illegal jump 0 -> 2, legal step down keeps sticky, then clear while idle
        do_reset();
        send(3'b000, 1'b0, pk(3'd0, 0, 0, 0, 0, 0, 2'd0, 8'h00));
        send(3'b011, 1'b0, pk(3'd2, 0, 0, 0, 1, 1, 2'd1, 8'h00));
        send(3'b001, 1'b0, pk(3'd1, 0, 1, 0, 0, 1, 2'd1, 8'hFF));
        idle(1, 1'b1, pk(3'd1, 0, 0, 0, 0, 0, 2'd0, 8'hFF), ST_TRACK);

        // hold, then in_valid low for three cycles
        send(3'b011, 1'b0, pk(3'd2, 1, 0, 0, 0, 0, 2'd0, 8'h00));
        send(3'b011, 1'b0, pk(3'd2, 0, 0, 1, 0, 0, 2'd0, 8'h00));
        idle(3, 1'b0, pk(3'd2, 0, 0, 0, 0, 0, 2'd0, 8'h00), ST_TRACK);

        // illegal jumps with err_clr on the third, then saturation
        send(3'b101, 1'b0, pk(3'd6, 0, 0, 0, 1, 1, 2'd1, 8'h00));
        send(3'b011, 1'b0, pk(3'd2, 0, 0, 0, 1, 1, 2'd2, 8'h00));
        send(3'b101, 1'b1, pk(3'd6, 0, 0, 0, 1, 1, 2'd1, 8'h00));
        send(3'b011, 1'b0, pk(3'd2, 0, 0, 0, 1, 1, 2'd2, 8'h00));
        for (int k = 0; k < 5; k++)
            send(alt_g[k % 2], 1'b0, pk(alt_b[k % 2], 0, 0, 0, 1, 1, 2'd3, 8'h00));
        idle(1, 1'b0, pk(3'd6, 0, 0, 0, 0, 1, 2'd3, 8'h00), ST_FAULT);

        // climb to pos_cnt=5 while still faulted, then reset mid-stream
        send(3'b100, 1'b0, pk(3'd7, 1, 0, 0, 0, 1, 2'd3, 8'd1));
        send(3'b000, 1'b0, pk(3'd0, 1, 0, 0, 0, 1, 2'd3, 8'd2));
        send(3'b001, 1'b0, pk(3'd1, 1, 0, 0, 0, 1, 2'd3, 8'd3));
        send(3'b011, 1'b0, pk(3'd2, 1, 0, 0, 0, 1, 2'd3, 8'd4));
        send(3'b010, 1'b0, pk(3'd3, 1, 0, 0, 0, 1, 2'd3, 8'd5));
        do_reset();
        send(3'b110, 1'b0, pk(3'd4, 0, 0, 0, 0, 0, 2'd0, 8'd0));
        idle(1, 1'b0, pk(3'd4, 0, 0, 0, 0, 0, 2'd0, 8'd0), ST_TRACK);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
